// File: rtl/systolic_pkg.sv
// Shared constants and helpers for the systolic matmul array processing elements.
package systolic_pkg;

  // Default operand and accumulator widths for a PE instance.
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;

  // Widest accumulator the helpers below handle. ACC_W must stay below this.
  localparam int MAX_W = 64;

  // Largest positive value of a w-bit two's-complement accumulator, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] acc_max(input int w);
    logic [MAX_W-1:0] one;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    return (one << (w - 1)) - one;
  endfunction

  // Most negative value of a w-bit accumulator, sign-extended to MAX_W.
  function automatic logic [MAX_W-1:0] acc_min(input int w);
    return ~acc_max(w);
  endfunction

  // Default-width clamp limits.
  localparam logic [MAX_W-1:0] DEF_ACC_MAX = acc_max(DEF_ACC_W);
  localparam logic [MAX_W-1:0] DEF_ACC_MIN = acc_min(DEF_ACC_W);

  // Sign-extend the low w bits of v to the full MAX_W width.
  function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int w);
    logic signed [MAX_W-1:0] t;
    t = v << (MAX_W - w);
    return t >>> (MAX_W - w);
  endfunction

endpackage

// File: rtl/systolic_pe_db_sat_acc.sv
// Combinational accumulate stage: acc + addend with overflow detect and optional clamp.
// Kept separate so a later bias-add stage can reuse it unchanged.
module pe_sat_acc
  import systolic_pkg::*;
#(
  parameter int ACC_W    = DEF_ACC_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] result,
  output logic             overflow
);

  localparam logic [MAX_W-1:0] MAX_FULL = acc_max(ACC_W);
  localparam logic [MAX_W-1:0] MIN_FULL = acc_min(ACC_W);
  localparam logic [ACC_W-1:0] MAX_V    = MAX_FULL[ACC_W-1:0];
  localparam logic [ACC_W-1:0] MIN_V    = MIN_FULL[ACC_W-1:0];

  logic [ACC_W:0] sum;

  // One guard bit: the top two bits of sum disagree exactly when the signed add overflowed,
  // and the guard bit then carries the true sign that selects the clamp direction.
  always_comb begin
    sum      = {acc[ACC_W-1], acc} + {addend[ACC_W-1], addend};
    overflow = sum[ACC_W] ^ sum[ACC_W-1];
    result   = sum[ACC_W-1:0];
    if (SATURATE && overflow) begin
      result = sum[ACC_W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/systolic_pe_db.sv
// Output-stationary systolic PE with a double-buffered result register.
// Operands travel east (a) and south (b) with their valid tag; finished tiles are
// captured into the result register and drained south on the psum chain while the
// next tile accumulates.
//
// Qualifier semantics: valid_in marks a_in/b_in as a real operand pair this cycle.
// There is no back-pressure; operands and the tag are forwarded every cycle and a
// PE only accumulates when valid_in is high. psum_valid_in/psum_valid_out tag the
// result chain the same way and move only on load_out or shift_en.
module systolic_pe_db
  import systolic_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              valid_out,
  input  logic              load_out,
  input  logic              shift_en,
  input  logic [ACC_W-1:0]  psum_in,
  input  logic              psum_valid_in,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_valid_out,
  output logic              psum_ovf_out
);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] prod;
  logic [MAX_W-1:0]    prod_full;
  logic [ACC_W-1:0]    prod_ext;
  logic                unused_prod_hi;

  logic [ACC_W-1:0]    acc;
  logic                ovf;
  logic [ACC_W-1:0]    sum_res;
  logic                sum_ovf;
  logic [ACC_W-1:0]    acc_next;
  logic                ovf_next;

  // Signed product: both operands sign-extended so the low 2*DATA_W bits are exact.
  always_comb begin
    a_ext     = {{DATA_W{a_in[DATA_W-1]}}, a_in};
    b_ext     = {{DATA_W{b_in[DATA_W-1]}}, b_in};
    prod      = a_ext * b_ext;
    prod_full = sext({{(MAX_W-2*DATA_W){1'b0}}, prod}, 2 * DATA_W);
    prod_ext  = prod_full[ACC_W-1:0];
  end

  assign unused_prod_hi = ^prod_full[MAX_W-1:ACC_W];

  pe_sat_acc #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_sat_acc (
    .acc      (acc),
    .addend   (prod_ext),
    .result   (sum_res),
    .overflow (sum_ovf)
  );

  // Candidate accumulator state; the overflow flag is sticky for the whole tile.
  always_comb begin
    acc_next = valid_in ? sum_res : acc;
    ovf_next = ovf | (valid_in & sum_ovf);
  end

  // Operand forwarding: one-cycle pipeline, independent of valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
    end else begin
      a_out     <= a_in;
      b_out     <= b_in;
      valid_out <= valid_in;
    end
  end

  // Accumulator: a load hands the tile off and starts the next tile from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (load_out || clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      acc <= acc_next;
      ovf <= ovf_next;
    end
  end

  // Result register: load captures the finished tile (including this cycle's product),
  // otherwise the column chain shifts or holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      psum_out       <= '0;
      psum_valid_out <= 1'b0;
      psum_ovf_out   <= 1'b0;
    end else if (load_out) begin
      psum_out       <= acc_next;
      psum_valid_out <= 1'b1;
      psum_ovf_out   <= ovf_next;
    end else if (shift_en) begin
      psum_out       <= psum_in;
      psum_valid_out <= psum_valid_in;
      psum_ovf_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_pe_db.sv
// Bench for systolic_pe_db: three instances (32-bit saturating, 16-bit saturating,
// 16-bit wrapping) share one stimulus stream and are checked against a reference model.
module tb_systolic_pe_db;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        valid_in = 1'b0;
  logic        load_out = 1'b0;
  logic        shift_en = 1'b0;
  logic        psum_valid_in = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic [31:0] psum_in = '0;

  logic [7:0]  a_o [3];
  logic [7:0]  b_o [3];
  logic        v_o [3];
  logic        pv  [3];
  logic        povf[3];
  logic [31:0] ps32;
  logic [15:0] ps16s;
  logic [15:0] ps16w;

  systolic_pe_db #(.DATA_W(8), .ACC_W(32), .SATURATE(1'b1)) u_dut32 (
    .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in),
    .a_in(a_in), .b_in(b_in), .a_out(a_o[0]), .b_out(b_o[0]), .valid_out(v_o[0]),
    .load_out(load_out), .shift_en(shift_en), .psum_in(psum_in),
    .psum_valid_in(psum_valid_in), .psum_out(ps32),
    .psum_valid_out(pv[0]), .psum_ovf_out(povf[0])
  );

  systolic_pe_db #(.DATA_W(8), .ACC_W(16), .SATURATE(1'b1)) u_sat16 (
    .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in),
    .a_in(a_in), .b_in(b_in), .a_out(a_o[1]), .b_out(b_o[1]), .valid_out(v_o[1]),
    .load_out(load_out), .shift_en(shift_en), .psum_in(psum_in[15:0]),
    .psum_valid_in(psum_valid_in), .psum_out(ps16s),
    .psum_valid_out(pv[1]), .psum_ovf_out(povf[1])
  );

  systolic_pe_db #(.DATA_W(8), .ACC_W(16), .SATURATE(1'b0)) u_wrap16 (
    .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in),
    .a_in(a_in), .b_in(b_in), .a_out(a_o[2]), .b_out(b_o[2]), .valid_out(v_o[2]),
    .load_out(load_out), .shift_en(shift_en), .psum_in(psum_in[15:0]),
    .psum_valid_in(psum_valid_in), .psum_out(ps16w),
    .psum_valid_out(pv[2]), .psum_ovf_out(povf[2])
  );

  // The controller must never issue a load and a shift together.
  always @(posedge clk) begin
    if (!rst) assert (!(load_out && shift_en)) else $error("load_out and shift_en asserted together");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  tag, $signed(got), got, $signed(exp), exp);
  endtask

  // ---------------- reference model ----------------
  int     acc_w[3] = '{32, 16, 16};
  bit     sat  [3] = '{1'b1, 1'b1, 1'b0};
  longint m_acc [3] = '{0, 0, 0};
  longint m_psum[3] = '{0, 0, 0};
  bit     m_ovf [3] = '{0, 0, 0};
  bit     m_pv  [3] = '{0, 0, 0};
  bit     m_povf[3] = '{0, 0, 0};
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;
  bit         m_v = 1'b0;

  function automatic longint wrap_to(input longint s, input int w);
    longint m;
    longint r;
    m = longint'(1) <<< w;
    r = s & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  function automatic longint got_psum(input int c);
    if (c == 0) return longint'($signed(ps32));
    if (c == 1) return longint'($signed(ps16s));
    return longint'($signed(ps16w));
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit cl, input bit v, input bit ld, input bit sh,
                      input int a, input int b, input longint pin, input bit pvin);
    longint prod, s, mx, mn, res, an;
    bit of, on;
    rst = r; clear = cl; valid_in = v; load_out = ld; shift_en = sh;
    a_in = a[7:0]; b_in = b[7:0]; psum_in = pin[31:0]; psum_valid_in = pvin;
    prod = longint'($signed(a_in)) * longint'($signed(b_in));
    for (int c = 0; c < 3; c++) begin
      mx  = (longint'(1) <<< (acc_w[c] - 1)) - 1;
      mn  = -mx - 1;
      s   = m_acc[c] + prod;
      of  = (s > mx) || (s < mn);
      res = !of ? s : (sat[c] ? ((s > mx) ? mx : mn) : wrap_to(s, acc_w[c]));
      an  = v ? res : m_acc[c];
      on  = m_ovf[c] | (v & of);
      if (r) begin
        m_acc[c] = 0; m_ovf[c] = 0; m_psum[c] = 0; m_pv[c] = 0; m_povf[c] = 0;
      end else begin
        if (ld) begin
          m_psum[c] = an; m_povf[c] = on; m_pv[c] = 1'b1;
        end else if (sh) begin
          m_psum[c] = wrap_to(pin, acc_w[c]); m_pv[c] = pvin; m_povf[c] = 1'b0;
        end
        if (ld || cl) begin
          m_acc[c] = 0; m_ovf[c] = 0;
        end else begin
          m_acc[c] = an; m_ovf[c] = on;
        end
      end
    end
    m_a = r ? 8'h00 : a_in;
    m_b = r ? 8'h00 : b_in;
    m_v = r ? 1'b0 : v;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(64'(m_psum[c]));
      exp_q.push_back(64'({m_pv[c], m_povf[c]}));
      exp_q.push_back(64'({m_v, m_a, m_b}));
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("psum%0d", c), 64'(got_psum(c)), exp_q.pop_front());
      check($sformatf("pflags%0d", c), 64'({pv[c], povf[c]}), exp_q.pop_front());
      check($sformatf("fwd%0d", c), 64'({v_o[c], a_o[c], b_o[c]}), exp_q.pop_front());
    end
  endtask

  // Directed result check against hand-derived constants.
  task automatic expect_res(input string tag, input longint e0, input longint e1, input longint e2,
                            input bit o0, input bit o1, input bit o2);
    longint e[3];
    bit     o[3];
    e = '{e0, e1, e2};
    o = '{o0, o1, o2};
    for (int c = 0; c < 3; c++) begin
      check($sformatf("%s_val%0d", tag, c), 64'(got_psum(c)), 64'(e[c]));
      check($sformatf("%s_ovf%0d", tag, c), 64'(povf[c]), 64'(o[c]));
      check($sformatf("%s_vld%0d", tag, c), 64'(pv[c]), 64'd1);
    end
  endtask

  task automatic mac(input int a, input int b);
    step(0, 0, 1, 0, 0, a, b, 0, 0);
  endtask

  task automatic load();
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_psum", 64'(ps32), 64'd0);
    check("reset_valid", 64'(pv[0]), 64'd0);

    // basic dot product
    mac(3, 4); mac(-2, 5); mac(7, -1); load();
    expect_res("dot", -5, -5, -5, 0, 0, 0);

    // positive overflow
    mac(127, 127); mac(127, 127); mac(127, 127); load();
    expect_res("pos_ovf", 48387, 32767, -17149, 0, 1, 1);

    // negative overflow
    mac(-128, 127); mac(-128, 127); mac(-128, 127); load();
    expect_res("neg_ovf", -48768, -32768, 16768, 0, 1, 1);

    // double buffer: tile A drains while tile B accumulates
    mac(2, 5); load();
    expect_res("tile_a", 10, 10, 10, 0, 0, 0);
    step(0, 0, 1, 0, 1, 2, 3, 99, 1);
    expect_res("shift_in", 99, 99, 99, 0, 0, 0);
    mac(2, 3); load();
    expect_res("tile_b", 12, 12, 12, 0, 0, 0);

    // invalid operands ignored
    mac(2, 2); step(0, 0, 0, 0, 0, 50, 50, 0, 0); load();
    expect_res("invalid", 4, 4, 4, 0, 0, 0);

    // clear mid-tile
    mac(5, 5); step(0, 1, 0, 0, 0, 0, 0, 0, 0); mac(1, 1); load();
    expect_res("clear", 1, 1, 1, 0, 0, 0);

    // clear and load together still capture this cycle's product
    mac(2, 3); step(0, 1, 1, 1, 0, 1, 1, 0, 0);
    expect_res("clr_ld", 7, 7, 7, 0, 0, 0);
    load();
    expect_res("zero_tile", 0, 0, 0, 0, 0, 0);

    // synchronous reset mid-drain
    mac(4, 4); load();
    expect_res("pre_drain", 16, 16, 16, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 5, 1);
    step(0, 0, 1, 0, 1, 3, 3, 7, 1);
    rst = 1'b1;
    #1;
    check("rst_before_edge", 64'(ps32), 64'd7);
    step(1, 0, 0, 0, 1, 0, 0, 8, 1);
    check("rst_after_edge", 64'(ps32), 64'd0);
    mac(1, 2); load();
    expect_res("post_rst", 2, 2, 2, 0, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      bit r, cl, v, ld, sh;
      r  = ($urandom_range(0, 60) == 0);
      cl = ($urandom_range(0, 15) == 0);
      v  = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 9) == 0);
      sh = !ld && ($urandom_range(0, 3) == 0);
      step(r, cl, v, ld, sh, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           longint'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/systolic_pe_db.md
Name: systolic_pe_db

Overview:
- Parametrised output-stationary processing element for the NxN systolic matmul array. It is the successor to the fixed 8-bit/32-bit PE.
- Adds configurable operand and accumulator widths, a valid qualifier that travels with the operands, and optional saturating accumulation with an overflow flag.
- Adds a double-buffered result register. A finished tile is drained through a column shift chain while the next tile accumulates.
- Instantiated N×N times by the array top. Operands flow east (a) and south (b); results shift south on the psum chain.

Parameters:
- DATA_W, 8, signed operand width for a and b.
- ACC_W, 32, signed accumulator and result width. Must be >= 2*DATA_W.
- SATURATE, 1. 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- clear  in  1  discard accumulator contents.
- valid_in  in  1  a_in/b_in qualify this cycle.
- a_in  in  DATA_W  signed operand from west.
- b_in  in  DATA_W  signed operand from north.
- a_out  out  DATA_W  registered a_in to east.
- b_out  out  DATA_W  registered b_in to south.
- valid_out  out  1  registered valid_in.
- load_out  in  1  end of tile: move accumulator to result register.
- shift_en  in  1  shift the result chain one step.
- psum_in  in  ACC_W  result from PE to the north.
- psum_valid_in  in  1  valid tag for psum_in.
- psum_out  out  ACC_W  result register.
- psum_valid_out  out  1  result register holds valid data.
- psum_ovf_out  out  1  overflow tag of the result register.

Behaviour:
- All state updates on posedge clk only. Reset is synchronous: every output and internal register goes to 0 (acc, ovf, a_out, b_out, valid_out, psum_out, psum_valid_out, psum_ovf_out). rst overrides all other inputs, including mid-tile and mid-drain.
- Forwarding, 1-cycle latency, unconditional when not in reset:
  - a_out <= a_in, b_out <= b_in, valid_out <= valid_in.
  - Operands are forwarded even when valid_in=0; downstream PEs gate on valid.
- Product: prod = a_in*b_in, signed, 2*DATA_W bits, sign-extended to ACC_W.
- Sum: sum = acc + prod, computed at ACC_W+1 bits.
  - Overflow = bit ACC_W differs from bit ACC_W-1.
  - SATURATE=1 and overflow: result = +max (2^(ACC_W-1)-1) if sum is positive, else -min (-2^(ACC_W-1)).
  - SATURATE=0: result = low ACC_W bits.
- acc_next = valid_in ? result : acc. ovf_next = ovf | (valid_in & overflow). ovf is sticky.
- Priority for acc/ovf, highest first:
  1. load_out: acc <= 0, ovf <= 0.
  2. clear: acc <= 0, ovf <= 0.
  3. otherwise: acc <= acc_next, ovf <= ovf_next.
- Result register, priority highest first:
  1. load_out: psum_out <= acc_next (includes this cycle's product), psum_ovf_out <= ovf_next, psum_valid_out <= 1. When clear and load_out coincide, the load still captures acc_next.
  2. shift_en: psum_out <= psum_in, psum_valid_out <= psum_valid_in, psum_ovf_out <= 0.
  3. otherwise: hold.
- load_out and shift_en in the same cycle: load wins and the shifted value is lost. The controller must not issue both; verification flags it with an assertion.
- A tile of K products plus load_out gives a valid result on psum_out in the cycle after the load_out edge.
- A column of N PEs drains in N shift_en cycles, bottom PE first. A new tile can accumulate during the drain with no bubble.
- Zero-length tile: load_out with acc=0 and no valid gives psum_out=0 and psum_valid_out=1.

Decomposition:
- Package systolic_pkg holds:
  - default DATA_W/ACC_W constants;
  - ACC_MAX/ACC_MIN derived from ACC_W;
  - a sign-extend helper.
- Sub-module pe_sat_acc: combinational acc+prod with overflow detect and clamp (params ACC_W, SATURATE). Reused by a future bias-add stage.
- systolic_pe_db holds all registers.

Test Plan:
- DATA_W=8, ACC_W=32. valid pairs (3,4),(-2,5),(7,-1) then load_out → psum_out=-5, psum_valid_out=1, psum_ovf_out=0. a_out/b_out/valid_out each lag their inputs by exactly 1 cycle.
- ACC_W=16, SATURATE=1. (127,127) ×3 then load → psum_out=32767, ovf=1. (-128,127) ×3 then load → -32768, ovf=1.
- ACC_W=16, SATURATE=0. (127,127) ×3 then load → psum_out=-17149 (48387-65536), ovf=1.
- Double-buffer: load tile A (=10), then accumulate tile B (2,3)×2 while shift_en for 1 cycle with psum_in=99, psum_valid_in=1. Response: psum_out=99 and the B load then yields 12. A's result does not corrupt B.
- Invalid/clear edges:
  - valid_in=0 with a_in=50, b_in=50 leaves acc unchanged.
  - clear mid-tile then (1,1) and load → 1.
  - clear+load_out together with acc=6 and valid (1,1) → psum_out=7, then acc=0.
- Sync reset mid-drain: assert rst for 1 cycle → all outputs 0 on the next edge (not before the edge). The following tile accumulates from 0.
